crc_frame_tx: RTL and testbench
===============================

// Module: crc_frame_tx
// PURPOSE
// - Upstream framer for the bit-serial CRC engine (crc): accepts payload bytes (valid/ready, last flag),
//   serializes them MSB-first onto tx_bit, and drives the engine's ctrl_en/data_in/ctrl_poly_en.
// - Appends CRC_W augmentation zeros, reads the engine's crc_seq, transmits the CRC MSB-first.
// - Receiver rerunning the engine over payload+CRC then sees zero remainder.
// PARAMETERS
// - CRC_W    4  CRC width; equals the engine's CRC_GPW_MAX
// - BYTE_W   8  payload word width
// PORTS
// - clk          in   1       clock
// - rst_n        in   1       synchronous, active-low reset
// - s_valid      in   1       payload byte valid
// - s_ready      out  1       framer accepts byte this cycle
// - s_data       in   BYTE_W  payload byte, bit BYTE_W-1 sent first
// - s_last       in   1       byte is last of frame
// - poly_cfg     in   CRC_W   polynomial tap enables; sampled on first byte of a frame
// - crc_ctrl_en  out  1       to engine ctrl_en
// - crc_data_in  out  1       to engine data_in
// - crc_poly_en  out  CRC_W   to engine ctrl_poly_en (latched poly_cfg)
// - crc_seq_in   in   CRC_W   from engine crc_seq
// - tx_bit       out  1       serial output bit
// - tx_valid     out  1       tx_bit meaningful
// - tx_sof       out  1       first payload bit of frame
// - tx_eof       out  1       last CRC bit of frame
// - err_underrun out  1       1-cycle pulse: mid-frame byte not available, frame aborted
// BEHAVIOUR
// - All outputs decoded from registers only; no input->output combinational path.
// - Reset: state IDLE, all outputs 0 except s_ready=0 during reset cycle, 1 in IDLE after; crc_poly_en=0.
// - Reset mid-frame: immediate return to IDLE; engine sees ctrl_en=0 and clears itself.
// - FSM IDLE -> DATA -> AUG -> CRC -> IDLE. Line rate 1 bit/cycle; no downstream stall.
// - IDLE: s_ready=1. On s_valid: load shift reg, latch poly_cfg, bit_cnt=0, last flag=s_last, go DATA.
// - DATA: tx_bit=crc_data_in=shreg MSB, tx_valid=1, crc_ctrl_en=1; tx_sof=1 on frame's first bit.
//   - s_ready=1 only in bit_cnt=BYTE_W-1 cycle of a non-last byte.
//   - That cycle: s_valid -> load next byte, stay DATA with no bubble.
//   - That cycle: !s_valid -> err_underrun pulse next cycle, go IDLE, crc_ctrl_en drops.
//   - Last byte bit BYTE_W-1 -> AUG.
// - AUG: CRC_W cycles, crc_ctrl_en=1, crc_data_in=0, tx_valid=0 (deliberate CRC_W-cycle gap).
// - CRC: CRC_W cycles, crc_ctrl_en=0, tx_valid=1.
//   - First cycle: tx_bit=crc_seq_in[CRC_W-1]; crc_seq_in[CRC_W-2:0] captured into crc shreg
//     (engine clears on the following edge).
//   - Remaining bits shifted MSB-first; tx_eof=1 on final bit; then IDLE.
// - Timing: byte accepted at edge 0 -> payload bits cycles 1..8N, AUG 8N+1..8N+W, CRC 8N+W+1..8N+2W.
// - Frame occupies 8N+2W cycles; s_ready high again the cycle after tx_eof.
// - Counters: bit_cnt clog2(BYTE_W), phase_cnt clog2(CRC_W); wrap to 0 on phase exit.
// - s_valid in AUG/CRC ignored (s_ready=0); poly_cfg changes mid-frame ignored.
// - Zero-length frames not supported: first byte always payload.
// STRUCTURE
// - crc_pkg: CRC_GPW_MAX, BYTE_W, state enum {IDLE,DATA,AUG,CRC}.
// - Sub-module crc_piso: loadable MSB-first shift register, reused for payload and CRC shreg.
// - FSM, counters, handshake in crc_frame_tx.
// - Top-level test wrapper instantiates crc_frame_tx + crc.
// TESTING
// - poly_cfg=4'b0011, one byte 0x01 last ->
//   tx 0000_0001 (cyc 1-8), gap 9-12, CRC 0011 (cyc 13-16), tx_eof@16.
// - poly_cfg=4'b0011, byte 0x80 last -> CRC 4'b1110; tx_sof on cycle 1 only.
// - poly_cfg=4'b0011, bytes 0x01,0x00 back-to-back ->
//   s_ready pulse at cycle 8, no bubble, CRC 4'b1111, tx_eof@24.
// - Two-byte frame, s_valid low at cycle 8 ->
//   err_underrun=1 at cycle 9, tx_valid=0, crc_ctrl_en=0, s_ready=1.
// - rst_n=0 during AUG of a frame ->
//   next cycle all outputs 0; new frame 0x01 gives CRC 0011 (engine clean).
// - Loopback via engine over emitted payload+CRC -> crc_seq==0 after last bit; random bytes/poly.

Source files
------------

// File: rtl/crc_frame_tx_pkg.sv
// Shared constants and FSM state encoding for the CRC frame transmitter.
package crc_frame_tx_pkg;

  // CRC width of the downstream bit-serial engine
  localparam int unsigned CRC_GPW_MAX = 4;
  // Default payload word width
  localparam int unsigned DEF_BYTE_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_AUG,
    S_CRC
  } state_e;

endpackage

// File: rtl/crc_frame_tx_if.sv
// Payload byte stream: valid/ready handshake with a last-of-frame flag.
interface crc_frame_tx_if #(
  parameter int unsigned BYTE_W = crc_frame_tx_pkg::DEF_BYTE_W
) ();

  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/crc_frame_tx_piso.sv
// Loadable MSB-first parallel-in/serial-out shift register; zeros fill from the LSB.
module crc_piso #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         msb
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Load has priority over shift
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_val;
    end else if (shift) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end
  end

  // Shift register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/crc_frame_tx.sv
// Framer in front of the bit-serial CRC engine: serializes payload bytes,
// feeds the engine, appends augmentation zeros, then transmits the CRC.
module crc_frame_tx
  import crc_frame_tx_pkg::*;
#(
  parameter int unsigned CRC_W  = CRC_GPW_MAX,
  parameter int unsigned BYTE_W = DEF_BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  crc_frame_tx_if.slave    s_if,
  input  logic [CRC_W-1:0] poly_cfg,
  output logic             crc_ctrl_en,
  output logic             crc_data_in,
  output logic [CRC_W-1:0] crc_poly_en,
  input  logic [CRC_W-1:0] crc_seq_in,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic             err_underrun
);

  localparam int unsigned BCW = $clog2(BYTE_W);
  localparam int unsigned PCW = $clog2(CRC_W);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(BYTE_W - 1);
  localparam logic [PCW-1:0] PHASE_LAST = PCW'(CRC_W - 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PCW-1:0]   phase_cnt_q, phase_cnt_d;
  logic             last_q, last_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic             sof_q, sof_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic accept;
  logic data_msb;
  logic crc_msb;
  logic crc_first;

  assign accept    = s_if.s_valid & ready_q;
  assign crc_first = (state_q == S_CRC) && (phase_cnt_q == '0);

  crc_piso #(.W(BYTE_W)) u_data_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift    (state_q == S_DATA),
    .load_val (s_if.s_data),
    .msb      (data_msb)
  );

  // Holds the lower CRC bits; the top bit is sent directly from the engine
  crc_piso #(.W(CRC_W)) u_crc_piso (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (crc_first),
    .shift    ((state_q == S_CRC) && !crc_first),
    .load_val ({crc_seq_in[CRC_W-2:0], 1'b0}),
    .msb      (crc_msb)
  );

  // Next-state, counters and handshake decode
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    phase_cnt_d = phase_cnt_q;
    last_d      = last_q;
    poly_d      = poly_q;
    sof_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          last_d    = s_if.s_last;
          poly_d    = poly_cfg;
          sof_d     = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (last_q) begin
            state_d = S_AUG;
          end else if (accept) begin
            last_d = s_if.s_last;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_AUG: begin
        if (phase_cnt_q == PHASE_LAST) begin
          phase_cnt_d = '0;
          state_d     = S_CRC;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      S_CRC: begin
        if (phase_cnt_q == PHASE_LAST) begin
          phase_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Ready is registered, so it is predicted from the next state
    ready_d = (state_d == S_IDLE) ||
              ((state_d == S_DATA) && (bit_cnt_d == BIT_LAST) && !last_d);
  end

  // FSM and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      phase_cnt_q <= '0;
      last_q      <= 1'b0;
      poly_q      <= '0;
      sof_q       <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      last_q      <= last_d;
      poly_q      <= poly_d;
      sof_q       <= sof_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign s_if.s_ready = ready_q;
  assign crc_poly_en  = poly_q;
  assign crc_ctrl_en  = (state_q == S_DATA) || (state_q == S_AUG);
  assign crc_data_in  = (state_q == S_DATA) && data_msb;
  assign tx_valid     = (state_q == S_DATA) || (state_q == S_CRC);
  assign tx_sof       = sof_q;
  assign tx_eof       = (state_q == S_CRC) && (phase_cnt_q == PHASE_LAST);
  assign err_underrun = err_q;

  // The engine's remainder is only final after the last AUG edge, so the
  // first CRC bit is taken from crc_seq_in directly in that cycle.
  assign tx_bit = (state_q == S_DATA) ? data_msb :
                  (state_q == S_CRC)  ? (crc_first ? crc_seq_in[CRC_W-1] : crc_msb) :
                                        1'b0;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Bench for crc_frame_tx with a behavioural model of the bit-serial CRC engine,
// a transmit-bit scoreboard and a receive-side loopback remainder check.
module tb_crc_frame_tx;

  localparam int W  = 4;
  localparam int BW = 8;

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] poly_cfg = '0;
  logic         crc_ctrl_en, crc_data_in;
  logic [W-1:0] crc_poly_en;
  logic [W-1:0] crc_seq_in;
  logic         tx_bit, tx_valid, tx_sof, tx_eof, err_underrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [W-1:0] cur_poly = '0;
  logic [W-1:0] rx_crc = '0;
  logic [W-1:0] rx_base, rx_next;
  exp_t         mon_e;

  crc_frame_tx_if #(.BYTE_W(BW)) s_if ();

  crc_frame_tx #(.CRC_W(W), .BYTE_W(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_if         (s_if),
    .poly_cfg     (poly_cfg),
    .crc_ctrl_en  (crc_ctrl_en),
    .crc_data_in  (crc_data_in),
    .crc_poly_en  (crc_poly_en),
    .crc_seq_in   (crc_seq_in),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid),
    .tx_sof       (tx_sof),
    .tx_eof       (tx_eof),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  // CRC engine model: clears whenever ctrl_en is low
  logic [W-1:0] eng = '0;
  always @(posedge clk) begin
    if (crc_ctrl_en !== 1'b1) eng <= '0;
    else eng <= {eng[W-2:0], crc_data_in} ^ (eng[W-1] ? crc_poly_en : '0);
  end
  assign crc_seq_in = eng;

  // Reference CRC by long division of payload * x^W by {1, poly}
  function automatic logic [W-1:0] crc_ref(input logic [7:0] d[$], input logic [W-1:0] poly);
    logic m[$];
    logic [W:0] g;
    logic [W-1:0] r;
    g = {1'b1, poly};
    foreach (d[i]) for (int j = BW - 1; j >= 0; j--) m.push_back(d[i][j]);
    for (int j = 0; j < W; j++) m.push_back(1'b0);
    for (int i = 0; i < m.size() - W; i++)
      if (m[i]) for (int j = 0; j <= W; j++) m[i+j] = m[i+j] ^ g[W-j];
    for (int j = 0; j < W; j++) r[W-1-j] = m[m.size() - W + j];
    return r;
  endfunction

  // Scoreboard monitor plus receiver remainder over payload+CRC
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_valid === 1'b1) begin
      rx_base = (tx_sof === 1'b1) ? '0 : rx_crc;
      rx_next = {rx_base[W-2:0], tx_bit} ^ (rx_base[W-1] ? cur_poly : '0);
      rx_crc  = rx_next;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_bit: got bit=%b sof=%b eof=%b, expected no transmission", tx_bit, tx_sof, tx_eof);
      end else begin
        mon_e = exp_q.pop_front();
        if ({tx_bit, tx_sof, tx_eof} !== {mon_e.b, mon_e.sof, mon_e.eof}) begin
          n_fail++;
          $display("FAIL sb_tx_bit @%0t: got bit/sof/eof=%b%b%b, expected %b%b%b",
                   $time, tx_bit, tx_sof, tx_eof, mon_e.b, mon_e.sof, mon_e.eof);
        end
        if (mon_e.eof) begin
          n_checks++;
          if (rx_next !== '0) begin
            n_fail++;
            $display("FAIL loopback_remainder: got %b, expected 0000", rx_next);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name, output bit ok);
    int tmo = 0;
    @(negedge clk);
    while (s_if.s_ready !== 1'b1 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    ok = (s_if.s_ready === 1'b1);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: s_ready=%b after %0d cycles, expected 1", name, s_if.s_ready, tmo);
    end
  endtask

  // Full frame with per-cycle control checks; expected bits go to the scoreboard
  task automatic run_frame(input logic [7:0] d[$], input logic [W-1:0] poly,
                           input logic [W-1:0] exp_crc, input string name);
    int n, t_end, idx;
    bit ok;
    logic ev, een, erdy;
    n = d.size();
    t_end = 8 * n + 2 * W + 1;
    foreach (d[i]) for (int j = BW - 1; j >= 0; j--)
      exp_q.push_back('{b: d[i][j], sof: (i == 0 && j == BW - 1), eof: 1'b0});
    for (int j = W - 1; j >= 0; j--) exp_q.push_back('{b: exp_crc[j], sof: 1'b0, eof: (j == 0)});
    wait_ready(name, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    cur_poly = poly;
    poly_cfg = poly;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d[0];
    s_if.s_last  = (n == 1);
    @(posedge clk);
    for (int c = 1; c <= t_end; c++) begin
      @(negedge clk);
      ev   = (c <= 8 * n) || (c > 8 * n + W && c <= 8 * n + 2 * W);
      een  = (c <= 8 * n + W);
      erdy = ((c % 8 == 0) && c < 8 * n) || (c == t_end);
      n_checks++;
      if ({tx_valid, crc_ctrl_en, s_if.s_ready, tx_sof, tx_eof, err_underrun} !==
          {ev, een, erdy, (c == 1), (c == 8 * n + 2 * W), 1'b0}) begin
        n_fail++;
        $display("FAIL %s_ctrl cyc%0d: got valid/en/rdy/sof/eof/err=%b%b%b%b%b%b, expected %b%b%b%b%b0",
                 name, c, tx_valid, crc_ctrl_en, s_if.s_ready, tx_sof, tx_eof, err_underrun,
                 ev, een, erdy, (c == 1), (c == 8 * n + 2 * W));
      end
      if (c == 2 || c == t_end - 1) begin
        n_checks++;
        if (crc_poly_en !== poly) begin
          n_fail++;
          $display("FAIL %s_poly cyc%0d: got %b, expected %b", name, c, crc_poly_en, poly);
        end
      end
      if (c == 3) poly_cfg = ~poly;
      if (c == t_end) begin
        s_if.s_valid = 1'b0;
      end else if ((c - 1) / 8 + 1 < n) begin
        idx = (c - 1) / 8 + 1;
        s_if.s_data = d[idx];
        s_if.s_last = (idx == n - 1);
      end else begin
        s_if.s_data = 8'($urandom);
        s_if.s_last = 1'($urandom);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover: %0d expected bits not transmitted, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_if.s_ready, crc_ctrl_en, crc_data_in, crc_poly_en, tx_bit, tx_valid, tx_sof, tx_eof, err_underrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b en=%b din=%b poly=%b bit=%b v=%b sof=%b eof=%b err=%b, expected all 0",
               s_if.s_ready, crc_ctrl_en, crc_data_in, crc_poly_en, tx_bit, tx_valid, tx_sof, tx_eof, err_underrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_if.s_ready, tx_valid, crc_ctrl_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_idle: got rdy/valid/en=%b%b%b, expected 100", s_if.s_ready, tx_valid, crc_ctrl_en);
    end
  endtask

  task automatic test_single_byte();
    run_frame('{8'h01}, 4'b0011, 4'b0011, "single_01");
  endtask

  task automatic test_msb_byte();
    run_frame('{8'h80}, 4'b0011, 4'b1110, "single_80");
  endtask

  task automatic test_back_to_back();
    run_frame('{8'h01, 8'h00}, 4'b0011, 4'b1111, "b2b_0100");
  endtask

  task automatic test_underrun();
    bit ok;
    logic ev, erdy;
    for (int j = BW - 1; j >= 0; j--) exp_q.push_back('{b: 1'(8'hA5 >> j), sof: (j == BW - 1), eof: 1'b0});
    wait_ready("underrun", ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    cur_poly = 4'b0011;
    poly_cfg = 4'b0011;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'hA5;
    s_if.s_last  = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) s_if.s_valid = 1'b0;
      ev   = (c <= 8);
      erdy = (c >= 8);
      n_checks++;
      if ({tx_valid, crc_ctrl_en, s_if.s_ready, err_underrun} !== {ev, ev, erdy, (c == 9)}) begin
        n_fail++;
        $display("FAIL underrun_ctrl cyc%0d: got valid/en/rdy/err=%b%b%b%b, expected %b%b%b%b",
                 c, tx_valid, crc_ctrl_en, s_if.s_ready, err_underrun, ev, ev, erdy, (c == 9));
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL underrun_leftover: %0d bits not transmitted, expected 0", exp_q.size());
      exp_q.delete();
    end
    run_frame('{8'h01}, 4'b0011, 4'b0011, "after_underrun");
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    for (int j = BW - 1; j >= 0; j--) exp_q.push_back('{b: (j == 0), sof: (j == BW - 1), eof: 1'b0});
    wait_ready("midreset", ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    cur_poly = 4'b0011;
    poly_cfg = 4'b0011;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 8'h01;
    s_if.s_last  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) s_if.s_valid = 1'b0;
      if (c == 10) begin
        n_checks++;
        if ({crc_ctrl_en, tx_valid} !== 2'b10) begin
          n_fail++;
          $display("FAIL midreset_in_aug: got en/valid=%b%b, expected 10", crc_ctrl_en, tx_valid);
        end
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({s_if.s_ready, crc_ctrl_en, crc_data_in, crc_poly_en, tx_bit, tx_valid, tx_sof, tx_eof, err_underrun} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got rdy=%b en=%b din=%b poly=%b bit=%b v=%b sof=%b eof=%b err=%b, expected all 0",
               s_if.s_ready, crc_ctrl_en, crc_data_in, crc_poly_en, tx_bit, tx_valid, tx_sof, tx_eof, err_underrun);
    end
    rst_n = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_leftover: %0d bits not transmitted, expected 0", exp_q.size());
      exp_q.delete();
    end
    run_frame('{8'h01}, 4'b0011, 4'b0011, "after_midreset");
  endtask

  task automatic test_random_loopback();
    logic [7:0] d[$];
    logic [W-1:0] poly;
    for (int f = 0; f < 8; f++) begin
      d.delete();
      for (int i = 0; i < $urandom_range(4, 1); i++) d.push_back(8'($urandom));
      poly = W'($urandom);
      run_frame(d, poly, crc_ref(d, poly), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_msb_byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_random_loopback();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
